tag_packer: RTL
===============

# tag_packer

Consumes the comparison `flag` and delayed sample `dout` produced by the threshold comparator in the time-tag datapath. It time-stamps each qualified rising edge of `flag` and buffers the tags in a small FIFO. Tags are emitted on an AXI4-Stream master towards the DMA/readout side, so this block is the reading end of the comparator's event interface.

## Interface
Parameters:
- `N`, 4: log2 of FIFO depth (depth = 2^N = 16).
- `TW`, 32: timestamp counter width.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `flag`  in  1  comparison flag from comparator.
- `dout`  in  16  delayed sample from comparator, aligned with `flag`.
- `EN_REG`  in  1  1 = tagging enabled, timestamp running.
- `DEAD_REG`  in  8  dead time in cycles after an accepted edge.
- `m_axis_tdata`  out  TW+16 (TW without macro)  {sample[15:0], timestamp[TW-1:0]}.
- `m_axis_tvalid`  out  1  tag available.
- `m_axis_tready`  in  1  downstream ready.
- `OVF_REG`  out  16  dropped-tag counter, saturating.
- `LEVEL_REG`  out  N+1  FIFO occupancy, 0..2^N.

## Operation
- Input stage: `flag`, `dout` and the timestamp counter value `t` are registered together at edge k. These are `flag_r`, `dout_r` and `t_r`. `flag_rr` holds the previous `flag_r`.
- Timestamp: `t` is cleared while `EN_REG`=0. When `EN_REG`=1 it increments by 1 each cycle. It wraps from 2^TW-1 to 0 with no side effect.
- Edge qualification: an edge is `flag_r`=1 & `flag_rr`=0 & `EN_REG`=1.
- Event FSM:
  - ARM: a qualified edge generates a tag. It loads the dead counter with `DEAD_REG` and goes to HOLD. If `DEAD_REG`=0, the FSM stays in ARM.
  - HOLD: the dead counter decrements each cycle and edges are ignored, not counted. The FSM returns to ARM on the cycle the counter reaches 0.
  - `EN_REG`=0 forces ARM and clears the dead counter.
- FIFO write: writes {`dout_r`, `t_r`} on a generated tag.
  - If the FIFO is full, the tag is dropped and `OVF_REG` increments, saturating at 0xFFFF. Dead time still starts.
  - Full is evaluated before any same-cycle pop. A write into a full FIFO is dropped even if a pop occurs in the same cycle.
- FIFO read: first-word-fall-through.
  - `m_axis_tvalid` = !empty and `m_axis_tdata` = head entry.
  - Pop occurs on `tvalid & tready`.
  - `tdata` is stable while `tvalid`=1 & `tready`=0.
- Simultaneous write and pop on a non-full, non-empty FIFO leaves `LEVEL_REG` unchanged.
- Write and pop on an empty FIFO: no pop (tvalid=0), the write is accepted, and the level becomes 1.
- The FIFO keeps draining while `EN_REG`=0.
- `OVF_REG` is cleared only by reset.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `OVF_REG`=0, `LEVEL_REG`=0, t=0, FSM=ARM, `flag_r`=`flag_rr`=0.
- `areset` mid-operation empties the FIFO and drops `tvalid` immediately (asynchronously). Stored tags are lost.
- Latency: `flag` rising is sampled at edge k and `flag_rr`=0 at edge k. The FIFO is written at edge k+1, and `tvalid` is high after edge k+1.
- Timestamp in the tag is the value of `t` sampled at edge k.
- Dead time: after a tag from the edge sampled at k, the next accepted edge can be sampled no earlier than edge k+1+`DEAD_REG`.
- Throughput: one tag per cycle in, one per cycle out.
- Minimum spacing of tags is 2 cycles, because a flag edge needs a 0 sample in between.
- `LEVEL_REG` updates at the same edge as the write or pop.

## Configuration
- `TAG_PACKER_SAMPLE_EN` defined:
  - the FIFO stores `dout_r`;
  - `m_axis_tdata` is TW+16 bits, {sample, timestamp}.
- Not defined:
  - `dout` is unused;
  - FIFO width and `m_axis_tdata` are TW bits, timestamp only.

## Test plan
- Single event: `EN_REG` rises at cycle 0, `DEAD_REG`=0, `tready`=1, and `flag` is 0→1 at sample edge 10 with `dout`=0x1234.
  - `tvalid` is high for 1 cycle after edge 11.
  - `tdata` = {0x1234, 10} relative to counter start.
- Dead time: `DEAD_REG`=5 and `flag` toggles 1010… every cycle → tags only at edges k, k+6, k+12, …; `OVF_REG`=0.
- Overflow: `tready`=0 and 20 isolated flag pulses with `DEAD_REG`=0.
  - `LEVEL_REG`=16 and `OVF_REG`=4.
  - Then `tready`=1: 16 tags drain in order with increasing timestamps.
- Backpressure: `tready` toggles randomly during 100 events → every accepted tag appears exactly once and in order, and `tdata` is held while stalled.
- Reset mid-operation: assert `areset` with `LEVEL_REG`=7.
  - `tvalid`=0 at once, and `LEVEL_REG`, `OVF_REG` and t are 0.
  - After release, the first tag is timestamped relative to the new count.
- Enable/wrap: with TW=8, an event 300 cycles after `EN_REG` rises carries timestamp 44. `EN_REG`=0 blocks tags while the FIFO still drains.

Source files
------------

// File: rtl/tag_packer.sv
// Time-tags qualified rising edges of the comparator flag and queues them in a
// first-word-fall-through FIFO drained over AXI4-Stream. Define TAG_PACKER_SAMPLE_EN to store the sample with each tag.
module tag_packer #(
  parameter int N  = 4,
  parameter int TW = 32
`ifdef TAG_PACKER_SAMPLE_EN
  , localparam int DW = TW + 16
`else
  , localparam int DW = TW
`endif
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          flag,
  input  logic [15:0]   dout,
  input  logic          EN_REG,
  input  logic [7:0]    DEAD_REG,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [15:0]   OVF_REG,
  output logic [N:0]    LEVEL_REG
);
  localparam int DEPTH = 2 ** N;

  typedef enum logic {ARM, HOLD} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [TW-1:0] t;
  logic [TW-1:0] t_r;
  logic          flag_r;
  logic          flag_rr;
  logic          rise;
  state_t        state_q, state_d;
  logic [7:0]    dead_q, dead_d;
  logic          tag;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem [DEPTH];
  logic [N-1:0]  wptr, rptr;
  logic [N:0]    count;
  logic [15:0]   ovf;
  logic          full, empty, wr, pop;

  // Input stage: flag, sample and timestamp captured on the same edge
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      t       <= '0;
      flag_r  <= 1'b0;
      flag_rr <= 1'b0;
    end else begin
      t       <= EN_REG ? t + TW'(1) : '0;
      flag_r  <= flag;
      flag_rr <= flag_r;
    end
  end

  always_ff @(posedge aclk) begin
    t_r <= t;
  end

`ifdef TAG_PACKER_SAMPLE_EN
  logic [15:0] dout_r;
  always_ff @(posedge aclk) begin
    dout_r <= dout;
  end
  assign wdata = {dout_r, t_r};
`else
  logic unused_dout;
  assign unused_dout = ^dout;
  assign wdata = t_r;
`endif

  assign rise = flag_r & ~flag_rr & EN_REG;

  // Event FSM: ARM accepts an edge, HOLD blanks edges for the dead time
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ARM;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    tag     = 1'b0;
    unique case (state_q)
      ARM: begin
        if (rise) begin
          tag = 1'b1;
          if (DEAD_REG != 8'd0) begin
            state_d = HOLD;
            dead_d  = DEAD_REG;
          end
        end
      end
      HOLD: begin
        dead_d = dead_q - 8'd1;
        if (dead_q == 8'd1) state_d = ARM;
      end
      default: state_d = ARM;
    endcase
    if (!EN_REG) begin
      state_d = ARM;
      dead_d  = '0;
    end
  end

  // FIFO stage: fullness is judged before a same-edge pop frees a slot
  assign full  = (count == (N+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = tag & ~full;
  assign pop   = ~empty & m_axis_tready;

  always_ff @(posedge aclk) begin
    if (wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= '0;
    end else begin
      if (wr)  wptr <= wptr + N'(1);
      if (pop) rptr <= rptr + N'(1);
      unique case ({wr, pop})
        2'b10:   count <= count + (N+1)'(1);
        2'b01:   count <= count - (N+1)'(1);
        default: count <= count;
      endcase
      if (tag && full) ovf <= sat_inc16(ovf);
    end
  end

  // Empty FIFO presents zero so the reset value of tdata is defined
  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = empty ? '0 : mem[rptr];
  assign OVF_REG       = ovf;
  assign LEVEL_REG     = count;

endmodule
